// File: rtl/countdown_timer_if.sv
// countdown_timer_if: control/status bundle between a timer master and the countdown_timer.
// Carries reload_mode only when COUNTDOWN_RELOAD_EN is defined.
interface countdown_timer_if #(
    parameter int COUNT_WIDTH = 3
);
    logic                   en;
    logic                   load;
    logic [COUNT_WIDTH-1:0] load_val;
    logic                   start;
    logic                   abort;
    logic [COUNT_WIDTH-1:0] count;
    logic                   busy;
    logic                   done;
`ifdef COUNTDOWN_RELOAD_EN
    logic                   reload_mode;

    modport master (
        output en, load, load_val, start, abort, reload_mode,
        input  count, busy, done
    );

    modport slave (
        input  en, load, load_val, start, abort, reload_mode,
        output count, busy, done
    );
`else
    modport master (
        output en, load, load_val, start, abort,
        input  count, busy, done
    );

    modport slave (
        input  en, load, load_val, start, abort,
        output count, busy, done
    );
`endif
endinterface

// File: rtl/countdown_timer.sv
// countdown_timer: loadable down-counter with one-cycle done pulse at terminal count.
// Define COUNTDOWN_RELOAD_EN to add bus.reload_mode for periodic auto-reload.
module countdown_timer #(
    parameter int COUNT_WIDTH = 3
) (
    input logic               clk,
    input logic               rst_n,
    countdown_timer_if.slave  bus
);
    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [COUNT_WIDTH-1:0] ONE = COUNT_WIDTH'(1);

    state_t                 state, state_n;
    logic [COUNT_WIDTH-1:0] count_q, count_n, reload_q, reload_n, period;
    logic                   busy_q, done_q, done_n, rmode;

`ifdef COUNTDOWN_RELOAD_EN
    assign rmode = bus.reload_mode;
`else
    assign rmode = 1'b0;
`endif

    // A simultaneous load supplies the period for a same-cycle start.
    assign period = bus.load ? bus.load_val : reload_q;

    always_comb begin
        state_n  = state;
        count_n  = count_q;
        reload_n = reload_q;
        done_n   = 1'b0;
        if (state == IDLE) begin
            if (bus.load) begin
                reload_n = bus.load_val;
                count_n  = bus.load_val;
            end
            if (bus.start && !bus.abort) begin
                if (period != '0) begin
                    state_n = RUN;
                    count_n = period;
                end else begin
                    done_n = 1'b1;
                end
            end
        end else if (bus.abort) begin
            state_n = IDLE;
        end else if (bus.en) begin
            if (count_q <= ONE) begin
                done_n  = 1'b1;
                count_n = rmode ? reload_q : '0;
                state_n = rmode ? RUN : IDLE;
            end else begin
                count_n = count_q - ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            count_q  <= '0;
            reload_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_n;
            count_q  <= count_n;
            reload_q <= reload_n;
            busy_q   <= (state_n == RUN);
            done_q   <= done_n;
        end
    end

    assign bus.count = count_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: scoreboard bench; a behavioural model queues expected outputs per clock.
// Define COUNTDOWN_RELOAD_EN to also exercise periodic reload.
module tb_countdown_timer;
    localparam int W = 3;

    typedef struct packed {
        logic [W-1:0] c;
        logic         b;
        logic         d;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   n;
    exp_t q[$];

    logic [W-1:0] m_cnt, m_rel;
    logic         m_busy;

    countdown_timer_if #(.COUNT_WIDTH(W)) bus ();

    countdown_timer #(.COUNT_WIDTH(W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input logic e, input logic l, input logic s, input logic a,
                        input logic [W-1:0] v);
        bus.en = e;
        bus.load = l;
        bus.start = s;
        bus.abort = a;
        bus.load_val = v;
        @(negedge clk);
    endtask

    // Steps with en=1 (or alternating 1,0,... when alt) until done, bounded by lim.
    task automatic run_until_done(input logic alt, input int lim, output int cycles);
        cycles = 0;
        do begin
            step(alt ? (cycles % 2 == 0) : 1'b1, 1'b0, 1'b0, 1'b0, '0);
            cycles++;
        end while (!bus.done && cycles < lim);
    endtask

    // Reference model: next outputs from the inputs seen at each rising edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt  <= '0;
            m_rel  <= '0;
            m_busy <= 1'b0;
            q.delete();
        end else begin : model
            logic [W-1:0] nc, nr;
            logic nb, nd, rm;
`ifdef COUNTDOWN_RELOAD_EN
            rm = bus.reload_mode;
`else
            rm = 1'b0;
`endif
            nc = m_cnt;
            nr = m_rel;
            nb = m_busy;
            nd = 1'b0;
            if (!m_busy) begin
                if (bus.load) begin
                    nr = bus.load_val;
                    nc = bus.load_val;
                end
                if (bus.start && !bus.abort) begin
                    if (nr != 0) begin
                        nb = 1'b1;
                        nc = nr;
                    end else begin
                        nd = 1'b1;
                    end
                end
            end else if (bus.abort) begin
                nb = 1'b0;
            end else if (bus.en) begin
                nc = m_cnt - 1'b1;
                if (nc == 0) begin
                    nd = 1'b1;
                    if (rm) nc = m_rel;
                    else nb = 1'b0;
                end
            end
            q.push_back('{c: nc, b: nb, d: nd});
            m_cnt  <= nc;
            m_rel  <= nr;
            m_busy <= nb;
        end
    end

    always @(negedge clk) begin
        if (rst_n && q.size() > 0) begin : cmp
            exp_t e;
            e = q.pop_front();
            chk("count", int'(bus.count), int'(e.c));
            chk("busy", int'(bus.busy), int'(e.b));
            chk("done", int'(bus.done), int'(e.d));
        end
    end

    initial begin
        bus.en = 1'b0;
        bus.load = 1'b0;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.load_val = '0;
`ifdef COUNTDOWN_RELOAD_EN
        bus.reload_mode = 1'b0;
`endif
        #1;
        chk("rst_count", int'(bus.count), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic run of 5
        step(1, 1, 0, 0, 5);
        step(1, 0, 1, 0, 0);
        chk("t2_start_count", int'(bus.count), 5);
        run_until_done(1'b0, 20, n);
        chk("t2_latency", n, 5);
        chk("t2_busy_end", int'(bus.busy), 0);
        step(0, 0, 0, 0, 0);
        chk("t2_done_pulse", int'(bus.done), 0);

        // Period 6 with en toggling; 6th enabled step is the 11th step
        step(1, 1, 1, 0, 6);
        run_until_done(1'b1, 40, n);
        chk("t3_latency", n, 11);

        // Abort at count 2, then re-run the retained period
        step(1, 1, 0, 0, 4);
        step(1, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 1, 0);
        chk("t4_abort_count", int'(bus.count), 2);
        chk("t4_abort_busy", int'(bus.busy), 0);
        chk("t4_abort_done", int'(bus.done), 0);
        step(1, 0, 1, 0, 0);
        chk("t4_restart_count", int'(bus.count), 4);
        run_until_done(1'b0, 20, n);
        chk("t4_latency", n, 4);

        // Abort in IDLE blocks start but not load
        step(1, 1, 1, 1, 3);
        chk("idle_abort_busy", int'(bus.busy), 0);
        chk("idle_abort_load", int'(bus.count), 3);

        // Zero period, then maximum period via load+start
        step(1, 1, 1, 0, 0);
        chk("t5_zero_done", int'(bus.done), 1);
        chk("t5_zero_busy", int'(bus.busy), 0);
        step(1, 1, 1, 0, 7);
        run_until_done(1'b0, 20, n);
        chk("t5_latency", n, 7);

        // Asynchronous reset in the middle of a run
        step(1, 1, 0, 0, 5);
        step(0, 0, 1, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("t1_async_count", int'(bus.count), 0);
        chk("t1_async_busy", int'(bus.busy), 0);
        chk("t1_async_done", int'(bus.done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 0, 1, 0, 0);
        chk("post_rst_zero_done", int'(bus.done), 1);

`ifdef COUNTDOWN_RELOAD_EN
        bus.reload_mode = 1'b1;
        step(1, 1, 1, 0, 3);
        for (int i = 0; i < 9; i++) begin
            step(1, 0, 0, 0, 0);
            chk("t6_tick", int'(bus.done), int'(i % 3 == 2));
        end
        chk("t6_reloaded", int'(bus.count), 3);
        bus.reload_mode = 1'b0;
        run_until_done(1'b0, 20, n);
        chk("t6_final_latency", n, 3);
        chk("t6_final_count", int'(bus.count), 0);
`endif

        for (int i = 0; i < 300; i++) begin
`ifdef COUNTDOWN_RELOAD_EN
            bus.reload_mode = ($urandom_range(0, 3) == 0);
`endif
            step($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0,
                 W'($urandom_range(0, (1 << W) - 1)));
        end
        step(0, 0, 0, 0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
